// File: rtl/vga_pkg.sv
// XGA (1024x768 @ 60 Hz) timing constants shared by the timing generator
// and by downstream drawing stages that need the screen bounds.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  localparam int SCREEN_X_MAX = XGA_H_ACTIVE - 1;
  localparam int SCREEN_Y_MAX = XGA_V_ACTIVE - 1;

endpackage

// File: rtl/vga_axis_decode.sv
// Combinational decode of one axis count into its blanking flag and sync level.
module vga_axis_decode
  import vga_pkg::*;
#(
  parameter int ACTIVE   = XGA_H_ACTIVE,
  parameter int FP       = XGA_H_FP,
  parameter int SYNC     = XGA_H_SYNC,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic [CNT_W-1:0] count,
  output logic             blank,
  output logic             sync
);

  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END    = CNT_W'(ACTIVE + FP + SYNC);

  logic sync_on;

  always_comb begin
    blank   = (count >= BLANK_START);
    sync_on = (count >= SYNC_START) && (count < SYNC_END);
    sync    = sync_on ? SYNC_POL : ~SYNC_POL;
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running video timing generator: pixel/line counters with registered
// sync and blanking flags decoded from the next count so all outputs align.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] hcount_p0;
  logic [CNT_W-1:0] vcount_p0;
  logic             hblnk_p0;
  logic             hsync_p0;
  logic             vblnk_p0;
  logic             vsync_p0;

  // Stage p0: next pixel position, decoded before it is registered
  always_comb begin
    hcount_p0 = hcount_out + ONE;
    vcount_p0 = vcount_out;
    if (hcount_out == H_LAST) begin
      hcount_p0 = '0;
      vcount_p0 = (vcount_out == V_LAST) ? '0 : vcount_out + ONE;
    end
  end

  vga_axis_decode #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .SYNC_POL (SYNC_POL)
  ) u_h_decode (
    .count (hcount_p0),
    .blank (hblnk_p0),
    .sync  (hsync_p0)
  );

  vga_axis_decode #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .SYNC_POL (SYNC_POL)
  ) u_v_decode (
    .count (vcount_p0),
    .blank (vblnk_p0),
    .sync  (vsync_p0)
  );

  // Stage p1: output registers, all describing the same pixel
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      hblnk_out       <= 1'b0;
      vblnk_out       <= 1'b0;
      hsync_out       <= ~SYNC_POL;
      vsync_out       <= ~SYNC_POL;
      frame_start_out <= 1'b1;
    end else begin
      hcount_out      <= hcount_p0;
      vcount_out      <= vcount_p0;
      hblnk_out       <= hblnk_p0;
      vblnk_out       <= vblnk_p0;
      hsync_out       <= hsync_p0;
      vsync_out       <= vsync_p0;
      frame_start_out <= (hcount_p0 == '0) && (vcount_p0 == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a shrunken raster so several whole
// frames fit in a short run; a second instance covers the inverted polarity.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] hcount, vcount, hcount_i, vcount_i;
  logic             hsync, hblnk, vsync, vblnk, fs;
  logic             hsync_i, hblnk_i, vsync_i, vblnk_i, fs_i;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk_in(clk), .rst(rst),
    .hcount_out(hcount), .hsync_out(hsync), .hblnk_out(hblnk),
    .vcount_out(vcount), .vsync_out(vsync), .vblnk_out(vblnk),
    .frame_start_out(fs)
  );

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut_inv (
    .clk_in(clk), .rst(rst),
    .hcount_out(hcount_i), .hsync_out(hsync_i), .hblnk_out(hblnk_i),
    .vcount_out(vcount_i), .vsync_out(vsync_i), .vblnk_out(vblnk_i),
    .frame_start_out(fs_i)
  );

  typedef struct {
    int h;
    int v;
    bit hb;
    bit vb;
    bit hs_on;
    bit vs_on;
    bit fs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pos   = 0;

  // Expected raster state at a linear pixel position within the frame.
  function automatic exp_t model(int p);
    exp_t e;
    e.h     = p % HT;
    e.v     = p / HT;
    e.hb    = (e.h >= HA);
    e.vb    = (e.v >= VA);
    e.hs_on = (e.h >= HA + HF) && (e.h < HA + HF + HS);
    e.vs_on = (e.v >= VA + VF) && (e.v < VA + VF + VS);
    e.fs    = (p == 0);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected picture for the next edge is queued.
  task automatic step(bit r);
    @(negedge clk);
    rst = r;
    pos = r ? 0 : (pos + 1) % FRAME;
    sb.push_back(model(pos));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hcount",      int'(hcount), e.h);
        chk("vcount",      int'(vcount), e.v);
        chk("hblnk",       int'(hblnk),  int'(e.hb));
        chk("vblnk",       int'(vblnk),  int'(e.vb));
        chk("hsync",       int'(hsync),  int'(!e.hs_on));
        chk("vsync",       int'(vsync),  int'(!e.vs_on));
        chk("frame_start", int'(fs),     int'(e.fs));
        chk("inv_hcount",  int'(hcount_i), e.h);
        chk("inv_vcount",  int'(vcount_i), e.v);
        chk("inv_hblnk",   int'(hblnk_i),  int'(e.hb));
        chk("inv_vblnk",   int'(vblnk_i),  int'(e.vb));
        chk("inv_hsync",   int'(hsync_i),  int'(e.hs_on));
        chk("inv_vsync",   int'(vsync_i),  int'(e.vs_on));
        chk("inv_frame_start", int'(fs_i), int'(e.fs));
      end
    end
  end

  initial begin : stimulus
    int guard;
    repeat (5) step(1'b1);
    repeat (2 * FRAME + 10) step(1'b0);

    // Reset while both sync pulses are active.
    guard = 0;
    while (pos != (VA + VF) * HT + (HA + HF + 1) && guard < 2 * FRAME) begin
      step(1'b0);
      guard++;
    end
    chk("reach_mid_sync", pos, (VA + VF) * HT + (HA + HF + 1));
    step(1'b1);
    repeat (FRAME + 5) step(1'b0);

    // Random resets sprinkled over free-running operation.
    repeat (3000) step($urandom_range(0, 199) == 0);
    repeat (3) step(1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running XGA video timing generator; the producer end of the pixel-timing bus that the drawing pipeline consumes. Emits horizontal/vertical pixel counters, sync pulses and blanking flags, one pixel per clock, all registered and mutually aligned. Sits at the head of the video chain: its outputs feed the first drawing stage directly.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, VESA XGA)

Ports:
- clk_in  input  1  pixel clock (65 MHz for XGA)
- rst  input  1  synchronous, active-high reset
- hcount_out  output  11  current pixel column, 0..H_TOTAL-1
- hsync_out  output  1  horizontal sync, level per SYNC_POL
- hblnk_out  output  1  high outside the visible column range
- vcount_out  output  11  current line, 0..V_TOTAL-1
- vsync_out  output  1  vertical sync, level per SYNC_POL
- vblnk_out  output  1  high outside the visible line range
- frame_start_out  output  1  one-cycle pulse when hcount_out==0 and vcount_out==0

## Operation
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Counter update every clock: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap goes to 0.
- Decode, per axis, applied to the same count presented on the outputs:
  - hblnk = hcount >= H_ACTIVE (1024..1343).
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183).
  - vblnk = vcount >= V_ACTIVE (768..805).
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776); vsync edges coincide with hcount_out==0.
- Inactive sync level = !SYNC_POL.
- frame_start_out high exactly at pixel (0,0), once per frame.
- Counts never exceed H_TOTAL-1 / V_TOTAL-1; 11-bit width covers totals up to 2047.

## Timing
- All outputs are flops; no combinational path from any input to any output.
- Decode is computed from next-count values so flags and counts on the outputs always describe the same pixel (zero skew between any two outputs).
- Reset (rst high at a clk_in edge): hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, hsync_out=vsync_out=!SYNC_POL, frame_start_out=1 (pixel (0,0) is presented). Held while rst high.
- First edge with rst low: hcount_out=1, frame_start_out=0.
- Reset mid-frame: next edge returns to pixel (0,0) regardless of position; no partial sync pulse is extended.
- Line period H_TOTAL cycles; frame period H_TOTAL*V_TOTAL = 1,083,264 cycles.

## Structure
- Shared package vga_pkg: XGA timing constants (H_/V_ ACTIVE, FP, SYNC, BP, TOTAL), count width constant (11). Downstream drawing stages use the same package for screen bounds (1023/767).
- One sub-module natural: vga_axis_decode (count -> blank, sync), instantiated once per axis with that axis's parameters.

## Test plan
- Reset: hold rst 5 cycles -> all outputs at reset values, hcount_out=vcount_out=0, frame_start_out=1, syncs high (SYNC_POL=0).
- Line: from reset, cycle 1024 -> hblnk_out rises at hcount_out=1024; hsync_out low for hcount_out 1048..1183 (136 cycles); hcount_out 1343 -> 0 and vcount_out 0 -> 1 on same edge.
- Frame: vblnk_out high vcount_out 768..805; vsync_out low for lines 771..776 (6*1344 = 8064 cycles), edges at hcount_out==0; vcount_out 805 -> 0 at hcount_out wrap.
- Period: frame_start_out pulses exactly every 1,083,264 cycles, width 1; hsync falling edges every 1344 cycles.
- Reset mid-frame: assert rst at (hcount 1100, vcount 773) during both syncs -> next edge pixel (0,0), syncs inactive, blanks low.
- Alignment check: scoreboard recomputes blank/sync from hcount_out/vcount_out every cycle over two full frames -> zero mismatches; also rerun with SYNC_POL=1 -> sync polarity inverted only.
